// File: rtl/frog_pkg.sv
// Shared definitions for the frog tug-of-war game: state encoding, track geometry,
// player index type, button indices and the saturating move helper.
package frog_pkg;

  localparam int POS_MAX_DEF = 18;
  localparam int POS_W       = 5;

  typedef logic [1:0] game_state_t;
  localparam game_state_t ST_IDLE = 2'd0;
  localparam game_state_t ST_PLAY = 2'd1;
  localparam game_state_t ST_WIN  = 2'd2;

  typedef logic player_t;
  localparam player_t PLAYER0 = 1'b0;
  localparam player_t PLAYER1 = 1'b1;

  localparam int BTN_GO   = 0;
  localparam int BTN_BACK = 1;

  // One step towards the top end (fwd=1) or towards 0, saturating at both ends.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                input logic             fwd,
                                                input logic [POS_W-1:0] pos_max);
    if (fwd) return (pos == pos_max) ? pos : pos + 1'b1;
    else     return (pos == '0)      ? pos : pos - 1'b1;
  endfunction

endpackage

// File: rtl/frog_btn_ctrl.sv
// Per-player button front end: 2-flop synchronizers, optional debounce (DEBOUNCE_EN),
// arm flag and single-cycle press decode.
module frog_btn_ctrl
  import frog_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_go_n,
  input  logic i_back_n,
  output logic o_go_press,
  output logic o_back_press,
  output logic o_both_press
);

  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_lvl;
  logic       r_arm;
  logic       w_any_low;
  logic       w_press;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1[BTN_GO]   <= i_go_n;
      r_sync1[BTN_BACK] <= i_back_n;
      r_sync2           <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_deb;
  logic [CNT_W-1:0] r_cnt [2];

  // The debounced level follows the synced level only after DEB_CYCLES
  // consecutive clocks of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb    <= 2'b11;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_lvl = r_deb;
`else
  assign w_lvl = r_sync2;
`endif

  assign w_any_low = ~&w_lvl;
  assign w_press   = r_arm & w_any_low;

  // Re-arms only after both buttons are seen released, so a held button fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_arm <= 1'b0;
    else        r_arm <= ~w_any_low;
  end

  assign o_go_press   = w_press & ~w_lvl[BTN_GO] &  w_lvl[BTN_BACK];
  assign o_back_press = w_press &  w_lvl[BTN_GO] & ~w_lvl[BTN_BACK];
  assign o_both_press = w_press & ~w_lvl[BTN_GO] & ~w_lvl[BTN_BACK];

endmodule

// File: rtl/frog_turn_arbiter.sv
// Two-player frog tug-of-war: turn arbitration, per-turn timeout, frog position and
// winner detection. Build with DEBOUNCE_EN defined to debounce the buttons.
module frog_turn_arbiter
  import frog_pkg::*;
#(
  parameter int POS_MAX     = POS_MAX_DEF,
  parameter int TURN_CYCLES = 1000,
  parameter int DEB_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               p0_go_n,
  input  logic               p0_back_n,
  input  logic               p1_go_n,
  input  logic               p1_back_n,
  output logic [POS_MAX:0]   frog,
  output logic [POS_W-1:0]   pos,
  output logic               turn,
  output logic [1:0]         game_state,
  output logic               winner,
  output logic               timeout
);

  localparam int               TMR_W      = $clog2(TURN_CYCLES);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TURN_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_START  = POS_W'(POS_MAX / 2);
  localparam logic [POS_W-1:0] POS_END    = POS_W'(POS_MAX);

  game_state_t      r_state;
  logic [POS_W-1:0] r_pos;
  player_t          r_turn;
  player_t          r_winner;
  logic             r_timeout;
  logic [TMR_W-1:0] r_timer;

  logic w_p0_go, w_p0_back, w_p0_both;
  logic w_p1_go, w_p1_back, w_p1_both;
  logic w_go, w_back, w_both, w_move;
  logic [POS_W-1:0] w_next_pos;

  frog_btn_ctrl #(.DEB_CYCLES(DEB_CYCLES)) u_p0_btn (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_go_n       (p0_go_n),
    .i_back_n     (p0_back_n),
    .o_go_press   (w_p0_go),
    .o_back_press (w_p0_back),
    .o_both_press (w_p0_both)
  );

  frog_btn_ctrl #(.DEB_CYCLES(DEB_CYCLES)) u_p1_btn (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_go_n       (p1_go_n),
    .i_back_n     (p1_back_n),
    .o_go_press   (w_p1_go),
    .o_back_press (w_p1_back),
    .o_both_press (w_p1_both)
  );

  // Only the player holding the turn can move; a both-buttons press is never a move.
  assign w_go       = (r_turn == PLAYER1) ? w_p1_go   : w_p0_go;
  assign w_back     = (r_turn == PLAYER1) ? w_p1_back : w_p0_back;
  assign w_both     = (r_turn == PLAYER1) ? w_p1_both : w_p0_both;
  assign w_move     = (r_state == ST_PLAY) && (w_go || w_back) && !w_both;
  assign w_next_pos = step_pos(r_pos, w_go, POS_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pos     <= POS_START;
      r_turn    <= PLAYER0;
      r_winner  <= PLAYER0;
      r_timeout <= 1'b0;
      r_timer   <= TMR_RELOAD;
    end else begin
      r_timeout <= 1'b0;
      if (start) begin
        r_state  <= ST_PLAY;
        r_pos    <= POS_START;
        r_turn   <= PLAYER0;
        r_winner <= PLAYER0;
        r_timer  <= TMR_RELOAD;
      end else if (r_state == ST_PLAY) begin
        if (w_move) begin
          // The end reached decides the winner, not the player who moved.
          r_pos   <= w_next_pos;
          r_turn  <= ~r_turn;
          r_timer <= TMR_RELOAD;
          if (w_next_pos == POS_END) begin
            r_state  <= ST_WIN;
            r_winner <= PLAYER0;
          end else if (w_next_pos == '0) begin
            r_state  <= ST_WIN;
            r_winner <= PLAYER1;
          end
        end else if (r_timer == '0) begin
          r_timeout <= 1'b1;
          r_turn    <= ~r_turn;
          r_timer   <= TMR_RELOAD;
        end else begin
          r_timer <= r_timer - 1'b1;
        end
      end
    end
  end

  assign frog       = {{POS_MAX{1'b0}}, 1'b1} << r_pos;
  assign pos        = r_pos;
  assign turn       = r_turn;
  assign game_state = r_state;
  assign winner     = r_winner;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_frog_turn_arbiter.sv
// Self-checking bench for frog_turn_arbiter: directed game scenarios plus random presses,
// compared each cycle against an event-level model of the game rules.
module tb_frog_turn_arbiter;

  localparam int POS_MAX = 18;
  localparam int TC      = 16;
  localparam int DEB     = 4;
`ifdef DEBOUNCE_EN
  localparam int D = DEB;
`else
  localparam int D = 0;
`endif
  localparam int LAT = 3 + D;
  localparam int MID = POS_MAX / 2;
  localparam int H   = D + 2;
  localparam int G   = D + 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             p0_go_n, p0_back_n, p1_go_n, p1_back_n;
  logic [POS_MAX:0] frog;
  logic [4:0]       pos;
  logic             turn;
  logic [1:0]       game_state;
  logic             winner;
  logic             timeout;

  frog_turn_arbiter #(
    .POS_MAX     (POS_MAX),
    .TURN_CYCLES (TC),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .p0_go_n    (p0_go_n),
    .p0_back_n  (p0_back_n),
    .p1_go_n    (p1_go_n),
    .p1_back_n  (p1_back_n),
    .frog       (frog),
    .pos        (pos),
    .turn       (turn),
    .game_state (game_state),
    .winner     (winner),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Game model: presses become events at absolute edge numbers; the turn timer is a deadline.
  int edge_n = 0;
  int m_state, m_pos, m_turn, m_winner, m_timeout, m_deadline;
  bit m_armed [2];
  bit suppress = 1'b0;
  int ev [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state    = 0;
    m_pos      = MID;
    m_turn     = 0;
    m_winner   = 0;
    m_timeout  = 0;
    m_deadline = 0;
    m_armed[0] = 1'b1;
    m_armed[1] = 1'b1;
    ev.delete();
  endtask

  task automatic model_step(input logic st);
    int         e;
    logic [1:0] c;
    e = ev.exists(edge_n) ? ev[edge_n] : 0;
    if (ev.exists(edge_n)) ev.delete(edge_n);
    m_timeout = 0;
    if (st) begin
      m_state    = 1;
      m_pos      = MID;
      m_turn     = 0;
      m_winner   = 0;
      m_deadline = edge_n + TC;
    end else if (m_state == 1) begin
      c = (m_turn == 1) ? 2'(e >> 2) : 2'(e);
      if (c == 2'b01 || c == 2'b10) begin
        if (c == 2'b01) m_pos = (m_pos == POS_MAX) ? POS_MAX : m_pos + 1;
        else            m_pos = (m_pos == 0) ? 0 : m_pos - 1;
        m_turn     = 1 - m_turn;
        m_deadline = edge_n + TC;
        if (m_pos == POS_MAX) begin
          m_state  = 2;
          m_winner = 0;
        end else if (m_pos == 0) begin
          m_state  = 2;
          m_winner = 1;
        end
      end else if (edge_n == m_deadline) begin
        m_timeout  = 1;
        m_turn     = 1 - m_turn;
        m_deadline = edge_n + TC;
      end
    end
  endtask

  task automatic compare_all();
    check("game_state", 32'(game_state), m_state);
    check("pos", 32'(pos), m_pos);
    check("frog", 32'(frog), 32'(1) << m_pos);
    check("turn", 32'(turn), m_turn);
    check("timeout", 32'(timeout), m_timeout);
    if (m_state == 2) check("winner", 32'(winner), m_winner);
  endtask

  // One clock: register any new press from the current levels, step the model, compare.
  task automatic tick();
    logic [3:0] lvl_low;
    lvl_low = {~p1_back_n, ~p1_go_n, ~p0_back_n, ~p0_go_n};
    for (int p = 0; p < 2; p++) begin
      logic [1:0] low2;
      low2 = lvl_low[2*p +: 2];
      if (m_armed[p] && low2 != 2'b00) begin
        if (!suppress) begin
          if (ev.exists(edge_n + LAT)) ev[edge_n + LAT] = ev[edge_n + LAT] | (int'(low2) << (2*p));
          else                         ev[edge_n + LAT] = int'(low2) << (2*p);
        end
        m_armed[p] = 1'b0;
      end else if (low2 == 2'b00) begin
        m_armed[p] = 1'b1;
      end
    end
    @(posedge clk);
    edge_n++;
    model_step(start);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input int p, input logic [1:0] low);
    if (p == 0) begin
      p0_go_n   = ~low[0];
      p0_back_n = ~low[1];
    end else begin
      p1_go_n   = ~low[0];
      p1_back_n = ~low[1];
    end
  endtask

  task automatic press(input int p, input logic [1:0] low, input int hold, input int gap);
    drive(p, low);
    repeat (hold) tick();
    drive(p, 2'b00);
    repeat (gap) tick();
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(game_state), 0);
    check("rst_pos", 32'(pos), MID);
    check("rst_frog", 32'(frog), 32'h0000_0200);
    check("rst_turn", 32'(turn), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_winner", 32'(winner), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    p0_go_n   = 1'b1;
    p0_back_n = 1'b1;
    p1_go_n   = 1'b1;
    p1_back_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset_now();
    repeat (3) tick();

    // First move: position steps on the LAT-th edge after the press is first sampled.
    start_game();
    drive(0, 2'b01);
    repeat (LAT - 1) tick();
    check("lat_before", 32'(pos), MID);
    tick();
    check("lat_pos", 32'(pos), MID + 1);
    check("lat_frog", 32'(frog), 32'h0000_0400);
    check("lat_turn", 32'(turn), 1);
    repeat (2) tick();
    drive(0, 2'b00);
    repeat (G) tick();
    press(0, 2'b10, H, G);
    check("inactive_back", 32'(pos), MID + 1);

    // Mid-game asynchronous reset.
    reset_now();
    repeat (2) tick();

    // Turn timeouts with no presses.
    start_game();
    repeat (TC - 1) tick();
    check("to1_early", 32'(timeout), 0);
    tick();
    check("to1_pulse", 32'(timeout), 1);
    check("to1_turn", 32'(turn), 1);
    check("to1_pos", 32'(pos), MID);
    repeat (TC - 1) tick();
    tick();
    check("to2_pulse", 32'(timeout), 1);
    check("to2_turn", 32'(turn), 0);

    // Race to the top end, then restart and race to position 0.
    start_game();
    for (int i = 0; i < 9; i++) press(i % 2, 2'b01, H, G);
    check("win0_state", 32'(game_state), 2);
    check("win0_pos", 32'(pos), POS_MAX);
    check("win0_winner", 32'(winner), 0);
    press(1, 2'b10, H, G);
    press(0, 2'b10, H, G);
    check("win0_frozen", 32'(pos), POS_MAX);
    start_game();
    check("restart_state", 32'(game_state), 1);
    check("restart_pos", 32'(pos), MID);
    check("restart_turn", 32'(turn), 0);
    for (int i = 0; i < 9; i++) press(i % 2, 2'b10, H, G);
    check("win1_state", 32'(game_state), 2);
    check("win1_pos", 32'(pos), 0);
    check("win1_winner", 32'(winner), 1);

    // Both buttons at once, and a button held across a turn change.
    start_game();
    press(0, 2'b11, H, G);
    check("both_pos", 32'(pos), MID);
    check("both_turn", 32'(turn), 0);
    drive(1, 2'b01);
    repeat (H) tick();
    press(0, 2'b01, H, D + 3);
    check("held_pos", 32'(pos), MID + 1);
    check("held_turn", 32'(turn), 1);
    drive(1, 2'b00);
    repeat (D + 3) tick();
    press(1, 2'b01, H, G);

`ifdef DEBOUNCE_EN
    // A glitch shorter than the debounce window never becomes a press.
    start_game();
    suppress = 1'b1;
    drive(0, 2'b01);
    repeat (3) tick();
    drive(0, 2'b00);
    suppress = 1'b0;
    repeat (4) tick();
    check("glitch_pos", 32'(pos), MID);
    drive(0, 2'b01);
    repeat (6) tick();
    check("deb_before", 32'(pos), MID);
    tick();
    check("deb_move", 32'(pos), MID + 1);
    repeat (3) tick();
    drive(0, 2'b00);
    repeat (G) tick();
`endif

    // Random play against the model.
    start_game();
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0 || (m_state != 1 && r < 5)) begin
        start_game();
      end else if (r == 1) begin
        press($urandom_range(0, 1), 2'b11, D + 1 + $urandom_range(0, 3), D + 3 + $urandom_range(0, 4));
      end else begin
        press($urandom_range(0, 1), ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10,
              D + 1 + $urandom_range(0, 3), D + 3 + $urandom_range(0, 4));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
